// File: rtl/sd_writer_if.sv
// sd_writer bus bundle: start/length request, block-buffer read port,
// DAT[3:0] pad signals and the completion/status report.
`timescale 1ns/1ps
interface sd_writer_if;
  logic       i_start_writing;
  logic [9:0] i_buf_len;
  logic [9:0] o_buf_addr;
  logic [7:0] i_buf_data;
  logic [3:0] o_sd_data;
  logic       o_sd_oe;
  logic [3:0] i_sd_data;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_status;
  logic       o_error;

  // Controller side: issues the request, serves the buffer, models the pads.
  modport master (
    output i_start_writing, i_buf_len, i_buf_data, i_sd_data,
    input  o_buf_addr, o_sd_data, o_sd_oe, o_busy, o_done, o_status, o_error
  );

  // Writer side.
  modport slave (
    input  i_start_writing, i_buf_len, i_buf_data, i_sd_data,
    output o_buf_addr, o_sd_data, o_sd_oe, o_busy, o_done, o_status, o_error
  );
endinterface

// File: rtl/sd_writer.sv
// SD 4-bit DAT transmit engine: start bit, nibble stream (high nibble first),
// per-line CRC16-CCITT, end bit, then CRC-status token and busy wait on DAT0.
`timescale 1ns/1ps
module sd_writer #(
  parameter int STAT_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 65535
) (
  input logic        clk,
  input logic        rst,
  sd_writer_if.slave bus
);
  // One shared counter covers the data phase (2*len <= 2046) and both timeouts.
  localparam int TW = $clog2((BUSY_TIMEOUT > STAT_TIMEOUT) ? BUSY_TIMEOUT + 1 : STAT_TIMEOUT + 1);
  localparam int CW = (TW > 11) ? TW : 11;
  // Timeouts compare two short of the limit because the completion pulse is
  // registered out of DONE, so o_done lands exactly at the limit.
  localparam logic [CW-1:0] STAT_LAST = CW'(STAT_TIMEOUT - 2);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT - 2);
  localparam logic [15:0]   POLY      = 16'h1021;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END,
    S_TURN, S_WAIT_STAT, S_STAT, S_BUSY, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [9:0]    len_reg, len_next;
  logic [9:0]    addr_reg, addr_next;
  logic [7:0]    byte_reg, byte_next;
  logic [2:0]    status_reg, status_next;
  logic          err_reg, err_next;
  logic          done_reg;
  logic          crc_clr, crc_upd, crc_shift;
  logic          oe;
  logic [3:0]    sd_out;
  logic [3:0]    nib;
  logic [3:0]    crc_msb;
  logic [CW-1:0] data_last;
  logic          dat0;
  logic          unused_dat;

  assign dat0       = bus.i_sd_data[0];
  assign unused_dat = ^bus.i_sd_data[3:1];
  assign nib        = cnt_reg[0] ? byte_reg[3:0] : byte_reg[7:4];
  assign data_last  = CW'({len_reg, 1'b0}) - CW'(1);

  // One CRC16 per DAT line; fed only with the data-phase bits of its line,
  // then shifted out MSB first during the CRC phase.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [15:0] crc_reg;

    // Per-line CRC register: clear on start, update in DATA, shift in CRC.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        crc_reg <= '0;
      else if (crc_clr)
        crc_reg <= '0;
      else if (crc_upd)
        crc_reg <= {crc_reg[14:0], 1'b0} ^ ({16{nib[gi] ^ crc_reg[15]}} & POLY);
      else if (crc_shift)
        crc_reg <= {crc_reg[14:0], 1'b0};
    end

    assign crc_msb[gi] = crc_reg[15];
  end

  // State and datapath registers; reset drops the bus via state IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      len_reg    <= '0;
      addr_reg   <= '0;
      byte_reg   <= '0;
      status_reg <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      len_reg    <= len_next;
      addr_reg   <= addr_next;
      byte_reg   <= byte_next;
      status_reg <= status_next;
      err_reg    <= err_next;
      done_reg   <= (state_reg == S_DONE);
    end
  end

  // Next-state, datapath updates and DAT drive for each phase.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    len_next    = len_reg;
    addr_next   = addr_reg;
    byte_next   = byte_reg;
    status_next = status_reg;
    err_next    = err_reg;
    crc_clr     = 1'b0;
    crc_upd     = 1'b0;
    crc_shift   = 1'b0;
    oe          = 1'b0;
    sd_out      = 4'hF;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.i_start_writing) begin
          status_next = '0;
          cnt_next    = '0;
          if (bus.i_buf_len == 10'd0) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            err_next   = 1'b0;
            len_next   = bus.i_buf_len;
            addr_next  = '0;
            crc_clr    = 1'b1;
            state_next = S_PRE;
          end
        end
      end
      S_PRE: begin
        oe         = 1'b1;
        state_next = S_START;
      end
      S_START: begin
        oe         = 1'b1;
        sd_out     = 4'h0;
        byte_next  = bus.i_buf_data;
        addr_next  = addr_reg + 10'd1;
        cnt_next   = '0;
        state_next = S_DATA;
      end
      S_DATA: begin
        oe      = 1'b1;
        sd_out  = nib;
        crc_upd = 1'b1;
        // Low nibble going out: the next byte has just arrived from the buffer.
        if (cnt_reg[0]) begin
          byte_next = bus.i_buf_data;
          addr_next = addr_reg + 10'd1;
        end
        if (cnt_reg == data_last) begin
          cnt_next   = '0;
          state_next = S_CRC;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_CRC: begin
        oe        = 1'b1;
        sd_out    = crc_msb;
        crc_shift = 1'b1;
        if (cnt_reg == CW'(15)) begin
          cnt_next   = '0;
          state_next = S_END;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_END: begin
        oe         = 1'b1;
        cnt_next   = '0;
        state_next = S_TURN;
      end
      S_TURN: begin
        if (cnt_reg[0]) begin
          cnt_next   = '0;
          state_next = S_WAIT_STAT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_WAIT_STAT: begin
        if (!dat0) begin
          cnt_next   = '0;
          state_next = S_STAT;
        end else if (cnt_reg == STAT_LAST) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_STAT: begin
        // Three status bits MSB first, then the end bit on the fourth cycle.
        if (cnt_reg == CW'(3)) begin
          if (!dat0 || status_reg != 3'b010)
            err_next = 1'b1;
          cnt_next   = '0;
          state_next = S_BUSY;
        end else begin
          status_next = {status_reg[1:0], dat0};
          cnt_next    = cnt_reg + CW'(1);
        end
      end
      S_BUSY: begin
        if (dat0) begin
          state_next = S_DONE;
        end else if (cnt_reg == BUSY_LAST) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_sd_oe    = oe;
  assign bus.o_sd_data  = sd_out;
  assign bus.o_buf_addr = addr_reg;
  assign bus.o_busy     = (state_reg != S_IDLE);
  assign bus.o_done     = done_reg;
  assign bus.o_status   = status_reg;
  assign bus.o_error    = err_reg;
endmodule
